// File: rtl/pkt_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_link_pkg
//  Purpose  : Constants shared by both ends of the inter-board packet link.
//             Covers the packet geometry, the frame sync pattern, the header
//             messages and the receiver state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package pkt_link_pkg;

    // Packet geometry: 2**LOGSIZE words of WIDTH bits each
    localparam int WIDTH   = 16;
    localparam int LOGSIZE = 4;

    // Framing and header words
    localparam int          SYNC_BITS      = 16;
    localparam logic [15:0] SYNC_WORD      = 16'hD391;
    localparam logic [15:0] ACK_MESSAGE    = 16'hAAAA;
    localparam logic [15:0] NO_ACK_MESSAGE = 16'h5555;

    // Receiver state encoding, kept numerically stable for the transmitter side
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_SYNC   = 3'd2;
    localparam logic [2:0] c_ST_DATA   = 3'd3;
    localparam logic [2:0] c_ST_CSUM   = 3'd4;
    localparam logic [2:0] c_ST_STOP   = 3'd5;
    localparam logic [2:0] c_ST_COMMIT = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = c_ST_IDLE,
        S_START  = c_ST_START,
        S_SYNC   = c_ST_SYNC,
        S_DATA   = c_ST_DATA,
        S_CSUM   = c_ST_CSUM,
        S_STOP   = c_ST_STOP,
        S_COMMIT = c_ST_COMMIT
    } rx_state_t;

    // Increment an 8-bit counter, holding at all-ones
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/link_bit_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : link_bit_sampler
//  Purpose  : Brings the raw serial line into the clock domain, detects the
//             falling edge that opens a frame and produces one sample strobe
//             per bit, the first one half a bit after the accepted edge.
//  Revision : 1.0 - initial release
// ============================================================================
module link_bit_sampler #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_serial,
    input  logic i_arm,            // receiver is ready to accept a new frame this cycle
    output logic o_start,          // accepted falling edge, counter restarts
    output logic o_sample_strobe,  // mid-bit sample point
    output logic o_sample_bit      // synchronised line value at the sample point
);

    localparam int                c_CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_prev;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_fall;

    // Two-flop synchroniser plus one history flop; idles high like the line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_serial;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_fall  = r_prev & ~r_sync2;
    assign o_start = w_fall & i_arm;

    // Bit-period counter: half a bit after an accepted edge, then every full bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= c_FULL_M1;
        end else if (o_start) begin
            r_cnt <= c_HALF_M1;
        end else if (r_cnt == '0) begin
            r_cnt <= c_FULL_M1;
        end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    assign o_sample_strobe = (r_cnt == '0);
    assign o_sample_bit    = r_sync2;

endmodule
`default_nettype wire

// File: rtl/packet_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : packet_receiver
//  Purpose  : Deserialises framed packets from the inter-board serial link
//             into a double-buffered packet memory. A frame is committed to
//             the front bank only after it has been received completely and
//             cleanly; the downstream reader never sees a partial packet.
//  Options  : PACKET_RX_CHECKSUM_EN - frame carries a trailing sum word that
//             must match the modulo-2**WIDTH sum of the data words.
//  Revision : 1.0 - initial release
// ============================================================================
module packet_receiver #(
    parameter int          WIDTH        = pkt_link_pkg::WIDTH,
    parameter int          LOGSIZE      = pkt_link_pkg::LOGSIZE,
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [15:0] SYNC_WORD    = pkt_link_pkg::SYNC_WORD
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               serial_in,
    input  logic [LOGSIZE-1:0] incoming_packet_read_index,
    output logic [WIDTH-1:0]   incoming_packet_read_data,
    output logic               incoming_packet_new,
    output logic               sync_error,
    output logic               frame_error,
    output logic [7:0]         drop_count
);

    import pkt_link_pkg::*;

    localparam int c_DEPTH   = 2 ** LOGSIZE;
    localparam int c_SHIFT_W = (WIDTH > SYNC_BITS) ? WIDTH : SYNC_BITS;
    localparam int c_BIT_W   = $clog2(c_SHIFT_W);

    rx_state_t            r_state;
    logic [c_SHIFT_W-1:0] r_shift;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [LOGSIZE-1:0]   r_word_idx;
    logic                 r_front;
    logic                 r_new;
    logic                 r_sync_err;
    logic                 r_frame_err;
    logic [7:0]           r_drop;
    logic [WIDTH-1:0]     r_bank0 [c_DEPTH];
    logic [WIDTH-1:0]     r_bank1 [c_DEPTH];
`ifdef PACKET_RX_CHECKSUM_EN
    logic [WIDTH-1:0]     r_sum;
`endif

    logic                 w_start;
    logic                 w_strobe;
    logic                 w_bit;
    logic                 w_arm;
    logic                 w_abort;
    logic [c_SHIFT_W-1:0] w_shift_next;
    logic [WIDTH-1:0]     w_word;
    logic                 w_sync_ok;
    logic                 w_last_sync;
    logic                 w_last_bit;
    logic                 w_last_word;
    logic                 w_word_wr;

    link_bit_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_sampler (
        .clk             (clock),
        .rst             (reset),
        .i_serial        (serial_in),
        .i_arm           (w_arm),
        .o_start         (w_start),
        .o_sample_strobe (w_strobe),
        .o_sample_bit    (w_bit)
    );

    assign w_shift_next = {r_shift[c_SHIFT_W-2:0], w_bit};
    assign w_word       = w_shift_next[WIDTH-1:0];
    assign w_sync_ok    = (w_shift_next[SYNC_BITS-1:0] == SYNC_WORD);
    assign w_last_sync  = (r_bit_cnt == c_BIT_W'(SYNC_BITS - 1));
    assign w_last_bit   = (r_bit_cnt == c_BIT_W'(WIDTH - 1));
    assign w_last_word  = (r_word_idx == {LOGSIZE{1'b1}});
    assign w_word_wr    = w_strobe && (r_state == S_DATA) && w_last_bit;

    // Flags the sample points that end a frame early, so an edge arriving in
    // that same cycle can open the next frame straight away
    always_comb begin
        w_abort = 1'b0;
        if (w_strobe) begin
            case (r_state)
                S_START: w_abort = w_bit;
                S_SYNC:  w_abort = w_last_sync && !w_sync_ok;
`ifdef PACKET_RX_CHECKSUM_EN
                S_CSUM:  w_abort = w_last_bit && (w_word != r_sum);
`endif
                S_STOP:  w_abort = ~w_bit;
                default: w_abort = 1'b0;
            endcase
        end
    end

    assign w_arm = (r_state == S_IDLE) || w_abort;

    // Frame sequencing, bank select, error pulses and drop counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_word_idx  <= '0;
            r_front     <= 1'b0;
            r_new       <= 1'b0;
            r_sync_err  <= 1'b0;
            r_frame_err <= 1'b0;
            r_drop      <= 8'd0;
`ifdef PACKET_RX_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_new       <= 1'b0;
            r_sync_err  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_START;
                        r_bit_cnt <= '0;
                    end
                end
                S_START: begin
                    if (w_strobe) begin
                        r_bit_cnt <= '0;
                        if (w_bit) begin
                            r_state <= w_start ? S_START : S_IDLE;
                        end else begin
                            r_state <= S_SYNC;
                        end
                    end
                end
                S_SYNC: begin
                    if (w_strobe) begin
                        r_shift <= w_shift_next;
                        if (w_last_sync) begin
                            r_bit_cnt  <= '0;
                            r_word_idx <= '0;
`ifdef PACKET_RX_CHECKSUM_EN
                            r_sum      <= '0;
`endif
                            if (w_sync_ok) begin
                                r_state <= S_DATA;
                            end else begin
                                r_sync_err <= 1'b1;
                                r_drop     <= sat_inc8(r_drop);
                                r_state    <= w_start ? S_START : S_IDLE;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (w_strobe) begin
                        r_shift <= w_shift_next;
                        if (w_last_bit) begin
                            r_bit_cnt <= '0;
`ifdef PACKET_RX_CHECKSUM_EN
                            r_sum     <= r_sum + w_word;
`endif
                            if (w_last_word) begin
`ifdef PACKET_RX_CHECKSUM_EN
                                r_state <= S_CSUM;
`else
                                r_state <= S_STOP;
`endif
                            end else begin
                                r_word_idx <= r_word_idx + LOGSIZE'(1);
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                        end
                    end
                end
`ifdef PACKET_RX_CHECKSUM_EN
                S_CSUM: begin
                    if (w_strobe) begin
                        r_shift <= w_shift_next;
                        if (w_last_bit) begin
                            r_bit_cnt <= '0;
                            if (w_word == r_sum) begin
                                r_state <= S_STOP;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_drop      <= sat_inc8(r_drop);
                                r_state     <= w_start ? S_START : S_IDLE;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (w_strobe) begin
                        r_bit_cnt <= '0;
                        if (w_bit) begin
                            r_state <= S_COMMIT;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_drop      <= sat_inc8(r_drop);
                            r_state     <= w_start ? S_START : S_IDLE;
                        end
                    end
                end
                S_COMMIT: begin
                    // Bank swap and the new-packet pulse land on the same edge
                    r_front <= ~r_front;
                    r_new   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Completed words go to whichever bank is currently at the back
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_bank0[i] <= '0;
                r_bank1[i] <= '0;
            end
        end else if (w_word_wr) begin
            if (r_front) begin
                r_bank0[r_word_idx] <= w_word;
            end else begin
                r_bank1[r_word_idx] <= w_word;
            end
        end
    end

    assign incoming_packet_read_data = r_front ? r_bank1[incoming_packet_read_index]
                                               : r_bank0[incoming_packet_read_index];
    assign incoming_packet_new       = r_new;
    assign sync_error                = r_sync_err;
    assign frame_error               = r_frame_err;
    assign drop_count                = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_packet_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_packet_receiver
//  Purpose  : Self-checking bench for packet_receiver. A packet-level model
//             holds the expected front bank and drop count; frames are
//             serialised bit by bit and every pulse must be the one expected,
//             inside a window derived from the frame bit position.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_packet_receiver;

    localparam int CPB = 16;
    localparam int NW  = 16;
    localparam int WB  = 16;
`ifdef PACKET_RX_CHECKSUM_EN
    localparam int CSUM_BITS = WB;
`else
    localparam int CSUM_BITS = 0;
`endif
    localparam int STOP_IDX = 1 + 16 + NW * WB + CSUM_BITS;

    localparam int K_NONE  = 0;
    localparam int K_NEW   = 1;
    localparam int K_SYNC  = 2;
    localparam int K_FRAME = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        serial_in;
    logic [3:0]  read_index;
    logic [15:0] read_data;
    logic        pkt_new;
    logic        sync_err;
    logic        frame_err;
    logic [7:0]  drop_count;

    packet_receiver #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock                      (clock),
        .reset                      (reset),
        .serial_in                  (serial_in),
        .incoming_packet_read_index (read_index),
        .incoming_packet_read_data  (read_data),
        .incoming_packet_new        (pkt_new),
        .sync_error                 (sync_err),
        .frame_error                (frame_err),
        .drop_count                 (drop_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] model_front [NW];
    logic [15:0] exp_data    [NW];
    logic [15:0] tx_words    [NW];
    int          model_drop  = 0;
    int          exp_kind    = K_NONE;
    int          exp_start   = 0;
    int          exp_lo      = 0;
    int          exp_hi      = 0;
    int          seen        = 0;
    bit          idx_auto    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cycle();
        @(posedge clock);
        #1;
    endtask

    // Decision at frame bit index idx (0 = start bit); pulse lands shortly after mid-bit
    task automatic expect_event(input int kind, input int idx);
        exp_kind = kind;
        seen     = 0;
        exp_lo   = idx * CPB + CPB / 2;
        exp_hi   = exp_lo + 8;
    endtask

    function automatic logic [15:0] words_sum();
        logic [15:0] s = 16'h0000;
        for (int i = 0; i < NW; i++) s = s + tx_words[i];
        return s;
    endfunction

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (CPB) wait_cycle();
    endtask

    task automatic send_frame(input logic [15:0] sync_w, input logic [15:0] csum_w,
                              input logic stop_b, input int max_bits);
        logic q[$];
        q.push_back(1'b0);
        for (int b = 15; b >= 0; b--) q.push_back(sync_w[b]);
        for (int w = 0; w < NW; w++)
            for (int b = WB - 1; b >= 0; b--) q.push_back(tx_words[w][b]);
`ifdef PACKET_RX_CHECKSUM_EN
        for (int b = WB - 1; b >= 0; b--) q.push_back(csum_w[b]);
`else
        if (csum_w != 16'h0000) q.push_back(1'b1);
        if (csum_w != 16'h0000) void'(q.pop_back());
`endif
        q.push_back(stop_b);
        exp_start = cyc;
        for (int i = 0; i < q.size() && i < max_bits; i++) drive_bit(q[i]);
        serial_in = 1'b1;
    endtask

    // Let the line idle long enough for any pending pulse, then confirm it arrived (or not)
    task automatic settle(input string name);
        repeat (3 * CPB) wait_cycle();
        check(name, seen, (exp_kind != K_NONE) ? 1 : 0);
        exp_kind = K_NONE;
        seen     = 0;
    endtask

    task automatic pin_word(input string name, input int i, input logic [15:0] v);
        idx_auto = 1'b0;
        wait_cycle();
        read_index = 4'(i);
        @(negedge clock);
        check(name, read_data, v);
        idx_auto = 1'b1;
    endtask

    task automatic pin_drop(input string name, input int v);
        @(negedge clock);
        check(name, {24'h0, drop_count}, v);
    endtask

    // Read index sweeps the bank continuously so the monitor sees every word
    initial begin
        read_index = 4'd0;
        forever begin
            @(posedge clock);
            #2;
            if (idx_auto) read_index = read_index + 4'd1;
        end
    end

    // Monitor: every pulse must be expected, single, in its window; model then follows it
    initial begin
        int kind_now;
        int npulse;
        int rel;
        forever begin
            @(negedge clock);
            npulse   = int'(pkt_new) + int'(sync_err) + int'(frame_err);
            kind_now = pkt_new ? K_NEW : (sync_err ? K_SYNC : (frame_err ? K_FRAME : K_NONE));
            if (npulse != 0) begin
                rel = cyc - exp_start;
                check("pulse_exclusive", npulse, 1);
                check("pulse_kind", kind_now, exp_kind);
                check("pulse_once", seen, 0);
                check("pulse_window", (rel >= exp_lo && rel <= exp_hi) ? 1 : 0, 1);
                seen = 1;
                if (kind_now == exp_kind && kind_now == K_NEW) begin
                    for (int i = 0; i < NW; i++) model_front[i] = exp_data[i];
                end else if (kind_now == exp_kind) begin
                    model_drop = (model_drop == 255) ? 255 : model_drop + 1;
                end
            end
            check("read_data", read_data, model_front[read_index]);
            check("drop_count", {24'h0, drop_count}, model_drop);
        end
    end

    initial begin
        repeat (90000) @(posedge clock);
        $display("FAIL watchdog: simulation did not complete, got cycle %0d, required < 90000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NW; i++) model_front[i] = 16'h0000;
        serial_in = 1'b1;
        reset     = 1'b1;

        // 1: reset state
        repeat (4) wait_cycle();
        check("reset_new",   pkt_new,   1'b0);
        check("reset_sync",  sync_err,  1'b0);
        check("reset_frame", frame_err, 1'b0);
        check("reset_drop",  {24'h0, drop_count}, 0);
        reset = 1'b0;
        repeat (4) wait_cycle();
        for (int i = 0; i < NW; i++) begin
            read_index = 4'(i);
            @(negedge clock);
            check("reset_word", read_data, 16'h0000);
            wait_cycle();
        end
        idx_auto = 1'b1;

        // 2: good frame, NO_ACK header then 1..15
        tx_words[0] = 16'h5555;
        for (int i = 1; i < NW; i++) tx_words[i] = 16'(i);
        for (int i = 0; i < NW; i++) exp_data[i] = tx_words[i];
        expect_event(K_NEW, STOP_IDX);
        send_frame(16'hD391, words_sum(), 1'b1, 1000);
        settle("good_frame_new");
        pin_word("t2_word0", 0, 16'h5555);
        pin_word("t2_word15", 15, 16'h000F);
        pin_word("t2_word7", 7, 16'h0007);

        // 3: corrupted sync word, line goes idle after it
        expect_event(K_SYNC, 16);
        send_frame(16'hD390, 16'h0000, 1'b1, 17);
        settle("sync_err_seen");
        pin_drop("t3_drop", 1);
        pin_word("t3_word0", 0, 16'h5555);

        // 4: full data but stop bit low
        for (int i = 0; i < NW; i++) tx_words[i] = 16'hF0F0 ^ 16'(i * 16'h0111);
        expect_event(K_FRAME, STOP_IDX);
        send_frame(16'hD391, words_sum(), 1'b0, 1000);
        settle("frame_err_seen");
        pin_drop("t4_drop", 2);
        pin_word("t4_word15", 15, 16'h000F);

        // 5: short low glitch on the idle line
        expect_event(K_NONE, 0);
        exp_start = cyc;
        serial_in = 1'b0;
        repeat (4) wait_cycle();
        serial_in = 1'b1;
        settle("glitch_silent");
        pin_drop("t5_drop", 2);

`ifdef PACKET_RX_CHECKSUM_EN
        // checksum word off by one, then a correct one
        for (int i = 0; i < NW; i++) tx_words[i] = 16'h8000 + 16'(i);
        expect_event(K_FRAME, STOP_IDX - 1);
        send_frame(16'hD391, words_sum() + 16'h0001, 1'b1, 1000);
        settle("csum_bad_seen");
        pin_drop("csum_bad_drop", 3);
        for (int i = 0; i < NW; i++) exp_data[i] = tx_words[i];
        expect_event(K_NEW, STOP_IDX);
        send_frame(16'hD391, words_sum(), 1'b1, 1000);
        settle("csum_good_new");
        pin_word("csum_word1", 1, 16'h8001);
`endif

        // 6: reset in the middle of word 7, then a good ACK frame
        for (int i = 0; i < NW; i++) tx_words[i] = 16'h1234 + 16'(i);
        expect_event(K_NONE, 0);
        send_frame(16'hD391, words_sum(), 1'b1, 1 + 16 + 7 * WB + 5);
        for (int i = 0; i < NW; i++) model_front[i] = 16'h0000;
        model_drop = 0;
        reset = 1'b1;
        repeat (3) wait_cycle();
        reset = 1'b0;
        settle("reset_midframe_silent");
        pin_drop("t6_drop", 0);
        pin_word("t6_word3", 3, 16'h0000);
        tx_words[0] = 16'hAAAA;
        for (int i = 1; i < NW; i++) tx_words[i] = 16'h0100 + 16'(i);
        for (int i = 0; i < NW; i++) exp_data[i] = tx_words[i];
        expect_event(K_NEW, STOP_IDX);
        send_frame(16'hD391, words_sum(), 1'b1, 1000);
        settle("ack_frame_new");
        pin_word("t6_word0", 0, 16'hAAAA);
        pin_word("t6_word5", 5, 16'h0105);

        repeat (4) wait_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
